// File: rtl/cls_64bit_if.sv
// Operand/result bundle for the 64-bit lookahead subtractor.
// The master drives operands and borrow-in; the slave returns registered results.
interface cls_64bit_if;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        bin;
   logic [63:0] diff;
   logic        gp;
   logic        gg;
   logic        bout;

   modport master (
      output in_a, in_b, bin,
      input  diff, gp, gg, bout
   );

   modport slave (
      input  in_a, in_b, bin,
      output diff, gp, gg, bout
   );
endinterface

// File: rtl/cls_64bit.sv
// 64-bit subtractor with a two-level borrow-lookahead tree and registered outputs.
// Bits are grouped into 16 blocks of 4, and the blocks into 4 groups of 4 blocks.
// A single top-level unit resolves the borrow into each group. Each group unit
// then resolves the borrow into each of its blocks, and each block unit resolves
// the borrow into each of its bits. Latency is one cycle. There is no handshake.
module cls_64bit (
   input  logic        clk,
   input  logic        rst,
   cls_64bit_if.slave  bus
);

   // 4-wide lookahead unit: borrows into positions 1..4 from the local generate,
   // the local propagate and the incoming borrow. Every term is expanded, so no
   // borrow ripples from one position to the next.
   function automatic logic [4:1] lac4(input logic [3:0] g,
                                       input logic [3:0] p,
                                       input logic       c0);
      logic [4:1] c;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return c;
   endfunction

   // Group generate and group propagate over 4 positions. The result is packed as {G, P}.
   function automatic logic [1:0] gp4(input logic [3:0] g,
                                      input logic [3:0] p);
      logic gg4;
      logic gp4v;
      gg4  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      gp4v = &p;
      return {gg4, gp4v};
   endfunction

   logic [63:0] w_g;      // per-bit borrow generate
   logic [63:0] w_p;      // per-bit borrow propagate
   logic [15:0] w_bg;     // block generate
   logic [15:0] w_bp;     // block propagate
   logic [3:0]  w_sg;     // group generate
   logic [3:0]  w_sp;     // group propagate
   logic        w_tg;     // top-level generate (ignores bin)
   logic        w_tp;     // top-level propagate
   logic [4:1]  w_sc;     // borrows out of each group
   logic [3:0]  w_sin;    // borrow into each group
   logic [15:0] w_bin;    // borrow into each block
   logic [63:0] w_c;      // borrow into each bit
   logic [63:0] w_diff;
   logic        w_bout;

   logic [63:0] r_diff;
   logic        r_gp;
   logic        r_gg;
   logic        r_bout;

   // Build the lookahead tree upward for (G,P), then distribute borrows downward.
   always_comb begin
      logic [1:0] t;
      logic [4:1] cc;
      w_g   = ~bus.in_a & bus.in_b;
      w_p   = ~(bus.in_a ^ bus.in_b);
      w_bg  = '0;
      w_bp  = '0;
      w_sg  = '0;
      w_sp  = '0;
      w_bin = '0;
      w_c   = '0;
      for (int unsigned j = 0; j < 16; j++) begin
         t       = gp4(w_g[j*4 +: 4], w_p[j*4 +: 4]);
         w_bg[j] = t[1];
         w_bp[j] = t[0];
      end
      for (int unsigned k = 0; k < 4; k++) begin
         t       = gp4(w_bg[k*4 +: 4], w_bp[k*4 +: 4]);
         w_sg[k] = t[1];
         w_sp[k] = t[0];
      end
      t    = gp4(w_sg, w_sp);
      w_tg = t[1];
      w_tp = t[0];
      w_sc  = lac4(w_sg, w_sp, bus.bin);
      w_sin = {w_sc[3:1], bus.bin};
      for (int unsigned k = 0; k < 4; k++) begin
         cc               = lac4(w_bg[k*4 +: 4], w_bp[k*4 +: 4], w_sin[k]);
         w_bin[k*4 +: 4]  = {cc[3:1], w_sin[k]};
      end
      for (int unsigned j = 0; j < 16; j++) begin
         cc             = lac4(w_g[j*4 +: 4], w_p[j*4 +: 4], w_bin[j]);
         w_c[j*4 +: 4]  = {cc[3:1], w_bin[j]};
      end
      w_diff = bus.in_a ^ bus.in_b ^ w_c;
      w_bout = w_tg | (w_tp & bus.bin);
   end

   // Register all results. A synchronous active-low reset clears them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_diff <= '0;
         r_gp   <= 1'b0;
         r_gg   <= 1'b0;
         r_bout <= 1'b0;
      end else begin
         r_diff <= w_diff;
         r_gp   <= w_tp;
         r_gg   <= w_tg;
         r_bout <= w_bout;
      end
   end

   assign bus.diff = r_diff;
   assign bus.gp   = r_gp;
   assign bus.gg   = r_gg;
   assign bus.bout = r_bout;

endmodule

// File: tb/tb_cls_64bit.sv
// Directed and random checks for the 64-bit lookahead subtractor.
module tb_cls_64bit;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   cls_64bit_if bus_if ();

   cls_64bit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one set of operands, let one rising edge pass, and sample 1 time unit after it.
   task automatic step(input logic [63:0] a, input logic [63:0] b, input logic c);
      bus_if.in_a = a;
      bus_if.in_b = b;
      bus_if.bin  = c;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [66:0] obs;
      rst = 1'b0;
      step(64'h1234, 64'h9999, 1'b1);
      obs = {bus_if.bout, bus_if.gp, bus_if.gg, bus_if.diff};
      n_cmp++;
      if (obs !== 67'd0) begin
         n_err++;
         $display("FAIL reset: got %h expected %h", obs, 67'd0);
      end
   endtask

   task automatic test_directed();
      logic [63:0] a [6];
      logic [63:0] b [6];
      logic        c [6];
      logic [66:0] e [6];
      logic [66:0] obs;
      // Each expected value is packed as {bout, gp, gg, diff}.
      a[0] = 64'd5;                  b[0] = 64'd3;   c[0] = 1'b0; e[0] = {3'b000, 64'd2};
      a[1] = 64'd0;                  b[1] = 64'd1;   c[1] = 1'b0; e[1] = {3'b101, 64'hFFFF_FFFF_FFFF_FFFF};
      a[2] = 64'h123;                b[2] = 64'h123; c[2] = 1'b1; e[2] = {3'b110, 64'hFFFF_FFFF_FFFF_FFFF};
      a[3] = 64'h123;                b[3] = 64'h123; c[3] = 1'b0; e[3] = {3'b010, 64'd0};
      a[4] = 64'hFFFF_FFFF_FFFF_FFFF; b[4] = 64'd0;  c[4] = 1'b1; e[4] = {3'b000, 64'hFFFF_FFFF_FFFF_FFFE};
      a[5] = 64'h0000_0001_0000_0000; b[5] = 64'd1;  c[5] = 1'b0; e[5] = {3'b000, 64'h0000_0000_FFFF_FFFF};
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(a[i], b[i], c[i]);
         obs = {bus_if.bout, bus_if.gp, bus_if.gg, bus_if.diff};
         n_cmp++;
         if (obs !== e[i]) begin
            n_err++;
            $display("FAIL directed[%0d]: got %h expected %h", i, obs, e[i]);
         end
      end
   endtask

   task automatic test_reset_release();
      logic [66:0] obs;
      rst = 1'b0;
      step(64'd7, 64'd9, 1'b0);
      obs = {bus_if.bout, bus_if.gp, bus_if.gg, bus_if.diff};
      n_cmp++;
      if (obs !== 67'd0) begin
         n_err++;
         $display("FAIL reset_priority: got %h expected %h", obs, 67'd0);
      end
      rst = 1'b1;
      step(64'd7, 64'd9, 1'b0);
      obs = {bus_if.bout, bus_if.gp, bus_if.gg, bus_if.diff};
      n_cmp++;
      if (obs !== {3'b101, 64'hFFFF_FFFF_FFFF_FFFE}) begin
         n_err++;
         $display("FAIL reset_release: got %h expected %h", obs, {3'b101, 64'hFFFF_FFFF_FFFF_FFFE});
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] a;
      logic [63:0] b;
      logic        c;
      logic [64:0] ref65;
      logic [66:0] exp_v;
      logic [66:0] obs;
      rst = 1'b1;
      for (int i = 0; i < 24; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         c = 1'($urandom_range(0, 1));
         if (i % 4 == 3) b = a;
         if (i % 6 == 5) b = a + 64'd1;
         ref65 = {1'b0, a} - {1'b0, b} - {64'd0, c};
         exp_v = {ref65[64], (a == b), (a < b), ref65[63:0]};
         step(a, b, c);
         obs = {bus_if.bout, bus_if.gp, bus_if.gg, bus_if.diff};
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL random[%0d] a=%h b=%h bin=%0d: got %h expected %h", i, a, b, c, obs, exp_v);
         end
      end
      // A reset in mid-stream discards the in-flight result.
      rst = 1'b0;
      step(64'd1, 64'd2, 1'b1);
      obs = {bus_if.bout, bus_if.gp, bus_if.gg, bus_if.diff};
      n_cmp++;
      if (obs !== 67'd0) begin
         n_err++;
         $display("FAIL midstream_reset: got %h expected %h", obs, 67'd0);
      end
      rst = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b0;
      bus_if.in_a = '0;
      bus_if.in_b = '0;
      bus_if.bin  = 1'b0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_reset_release();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
